// File: rtl/if_fetch_queue_if.sv
// Fetch-side signal bundle: memory request/response, predictor lookup, execute
// redirect and decode handoff. master = fetch unit, slave = its environment.
interface if_fetch_queue_if;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic [31:0] pred_addr;
    logic        pred_jmp;
    logic [31:0] pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        id_ready;

    modport master (
        input  rdy, mem_valid, mem_inst, pred_jmp, pred_target,
               redirect, redirect_pc, id_ready,
        output mem_req, mem_addr, pred_addr, if_valid, if_inst, if_pc,
               if_pred_taken, if_pred_target
    );

    modport slave (
        output rdy, mem_valid, mem_inst, pred_jmp, pred_target,
               redirect, redirect_pc, id_ready,
        input  mem_req, mem_addr, pred_addr, if_valid, if_inst, if_pc,
               if_pred_taken, if_pred_target
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch with one outstanding request feeding a QDEPTH-entry queue; mem_valid -> if_valid 1 cycle.
// Backpressure: id_ready stalls pops, a full queue stops issue, rdy=0 freezes everything.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.master fq
);
    localparam int unsigned   PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned   CW    = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_mem    [QDEPTH];
    logic [31:0] inst_mem  [QDEPTH];
    logic        taken_mem [QDEPTH];
    logic [31:0] tgt_mem   [QDEPTH];

    logic issue;
    logic push;
    logic pop;

    // Redirect outranks everything: it blocks issue, push and pop in its cycle.
    assign issue = rst && fq.rdy && (state_q == IDLE) && (count_q < DEPTH) && !fq.redirect;
    assign push  = fq.rdy && (state_q == WAIT) && fq.mem_valid && !fq.redirect;
    assign pop   = fq.rdy && (count_q != '0) && fq.id_ready && !fq.redirect;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.rdy) begin
            if (fq.redirect) begin
                pc_d     = fq.redirect_pc;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                // An in-flight response must still be swallowed after a flush.
                case (state_q)
                    WAIT:    state_d = fq.mem_valid ? IDLE : DROP;
                    DROP:    state_d = fq.mem_valid ? IDLE : DROP;
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    IDLE: if (issue) state_d = WAIT;
                    WAIT: if (fq.mem_valid) begin
                        state_d = IDLE;
                        pc_d    = fq.pred_jmp ? fq.pred_target : pc_q + 32'd4;
                    end
                    DROP: if (fq.mem_valid) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
                if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            inst_mem[wr_ptr_q]  <= fq.mem_inst;
            taken_mem[wr_ptr_q] <= fq.pred_jmp;
            tgt_mem[wr_ptr_q]   <= fq.pred_target;
        end
    end

    assign fq.mem_req        = issue;
    assign fq.mem_addr       = pc_q;
    assign fq.pred_addr      = pc_q;
    assign fq.if_valid       = (count_q != '0);
    assign fq.if_pc          = pc_mem[rd_ptr_q];
    assign fq.if_inst        = inst_mem[rd_ptr_q];
    assign fq.if_pred_taken  = taken_mem[rd_ptr_q];
    assign fq.if_pred_target = tgt_mem[rd_ptr_q];
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 4, the fetch-queue depth in entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port rdy, input, 1, global enable; when low, all state is frozen.
REQ-006 SHALL have port mem_req, output, 1, a one-cycle fetch request pulse.
REQ-007 SHALL have port mem_addr, output, 32, the fetch address, valid while mem_req=1.
REQ-008 SHALL have port mem_valid, input, 1, a one-cycle pulse that returns the instruction for the outstanding request.
REQ-009 SHALL have port mem_inst, input, 32, the returned instruction, valid with mem_valid.
REQ-010 SHALL have port pred_addr, output, 32, the current fetch PC, driven to the branch predictor.
REQ-011 SHALL have port pred_jmp, input, 1, the predictor's taken indication for pred_addr (combinational).
REQ-012 SHALL have port pred_target, input, 32, the predicted target for pred_addr.
REQ-013 SHALL have port redirect, input, 1, an execute-stage misprediction or flush request.
REQ-014 SHALL have port redirect_pc, input, 32, the corrected PC, valid with redirect.
REQ-015 SHALL have port if_valid, output, 1, asserted when the queue head is valid.
REQ-016 SHALL have port if_inst, output, 32, the head instruction.
REQ-017 SHALL have port if_pc, output, 32, the head PC.
REQ-018 SHALL have port if_pred_taken, output, 1, the head's prediction bit.
REQ-019 SHALL have port if_pred_target, output, 32, the head's predicted target.
REQ-020 SHALL have port id_ready, input, 1; the decoder accepts the head when if_valid && id_ready.

Function
REQ-021 SHALL implement the FSM states IDLE, WAIT and DROP, with at most one outstanding request.
REQ-022 In IDLE with count<QDEPTH and no redirect, SHALL pulse mem_req with mem_addr=pc and move to WAIT.
REQ-023 In WAIT on mem_valid, SHALL push {pc, mem_inst, pred_jmp, pred_target} and return to IDLE.
REQ-024 On the same edge as the push, SHALL load pc with pred_target if pred_jmp=1, else pc+4 (mod 2^32).
REQ-025 On redirect, SHALL load pc with redirect_pc, empty the queue (count=0, pointers reset), and ignore id_ready that cycle; redirect has top priority.
REQ-026 Redirect in IDLE SHALL leave the FSM in IDLE with no mem_req that cycle.
REQ-027 Redirect in WAIT without mem_valid SHALL move the FSM to DROP.
REQ-028 Redirect in WAIT with a simultaneous mem_valid SHALL discard the data and move the FSM to IDLE.
REQ-029 In DROP, mem_valid SHALL be discarded with a move to IDLE; a further redirect in DROP only updates pc.
REQ-030 Queue behaviour SHALL be a circular FIFO of QDEPTH entries with wrap-around pointers.
REQ-031 A same-cycle push and pop SHALL keep count unchanged.
REQ-032 The queue SHALL never overflow, because issue is gated by count<QDEPTH.
REQ-033 A pop on an empty queue SHALL be impossible (if_valid=0).
REQ-034 if_* outputs SHALL reflect the head combinationally from the storage registers; the minimum latency from mem_valid to if_valid is 1 cycle.
REQ-035 With rdy=0, SHALL hold pc, FSM, queue and count, and drive mem_req=0; a mem_valid arriving with rdy=0 is not the memory's responsibility to re-send, and the system guarantees rdy=1 whenever mem_valid=1.
REQ-036 pred_addr SHALL equal pc at all times.

Reset
REQ-037 On rst=0, asynchronously: pc=RESET_PC, FSM=IDLE, count=0, pointers=0, mem_req=0, if_valid=0; queue data contents are don't-care.
REQ-038 Reset mid-WAIT SHALL abandon the outstanding request, and any later mem_valid arriving in IDLE SHALL be ignored.

Verification
REQ-039 Reset release, memory returns 1-cycle responses, pred_jmp=0, id_ready=1 -> mem_addr sequence 0,4,8,C; if_pc follows in order.
REQ-040 pred_jmp=1 with pred_target=0x100 at pc=0x8 -> the next mem_addr is 0x100; the entry for 0x8 has if_pred_taken=1 and if_pred_target=0x100.
REQ-041 id_ready=0 with QDEPTH=4 -> exactly 4 pushes, then no mem_req; one pop -> one new request.
REQ-042 redirect to 0x200 in WAIT, with mem_valid 3 cycles later -> data discarded, queue empty, next mem_addr=0x200.
REQ-043 redirect coincident with mem_valid -> no push, FSM IDLE, next mem_addr=redirect_pc.
REQ-044 rst asserted while in WAIT with 2 entries queued -> if_valid=0 immediately, the next request goes to RESET_PC, and the stale mem_valid is ignored.
